ones_pattern_gen: RTL

- Inverse of the team's popcount block. It takes a requested ones-count N and a start bit position, and builds a DATA_WIDTH-bit mask containing exactly N ones.
- The ones are contiguous from the start position upward, wrapping around past the MSB.
- The mask is built iteratively, one bit per cycle, behind valid/ready handshakes on both sides.
- Used to generate enable/thermometer masks and as a stimulus source whose output popcount must equal the request.

---
 rtl/ones_pattern_gen.sv | 56 +++++
 1 files changed

// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: builds a DATA_WIDTH-bit mask of min(cnt,DATA_WIDTH) contiguous ones from start, wrapping past the MSB
module ones_pattern_gen #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(DATA_WIDTH):0]   cnt,
  input  logic [$clog2(DATA_WIDTH)-1:0] start,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic [$clog2(DATA_WIDTH):0]   dout_cnt,
  output logic                          sat
);
  localparam int AW = $clog2(DATA_WIDTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);
  typedef enum logic [1:0] {IDLE, BUILD, DONE} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] pos;
  logic [CW-1:0] rem, n;
  logic acc;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    n = (cnt > FULL) ? FULL : cnt;
    acc = in_valid && in_ready;
    state_nxt = (state == IDLE)  ? (acc ? ((n == '0) ? DONE : BUILD) : IDLE) :
                (state == BUILD) ? ((rem == CW'(1)) ? DONE : BUILD) :
                (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nxt;
  // start can only be out of range when DATA_WIDTH is not a power of two
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      dout     <= '0;
      dout_cnt <= '0;
      sat      <= 1'b0;
      pos      <= '0;
      rem      <= '0;
    end else if (acc) begin
      dout     <= '0;
      dout_cnt <= n;
      sat      <= cnt > FULL;
      pos      <= ({1'b0, start} >= FULL) ? '0 : start;
      rem      <= n;
    end else if (state == BUILD) begin
      dout[pos] <= 1'b1;
      pos       <= (pos == AW'(DATA_WIDTH - 1)) ? '0 : pos + 1'b1;
      rem       <= rem - 1'b1;
    end
endmodule
